// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit for the 16-bit TSC datapath.
// Sequences IF -> ID -> EX -> MEM -> WB, drives every datapath strobe and
// mux select, and holds memory requests open until mem_ack.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic [5:0] funct,
  input  logic       bcond,
  input  logic       mem_ack,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_pc_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       output_active,
  output logic       inst_done,
  output logic       halted,
  output logic [2:0] state
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ALU_LAST = 6'd7;
  localparam logic [5:0] FN_JPR      = 6'd25;
  localparam logic [5:0] FN_JRL      = 6'd26;
  localparam logic [5:0] FN_WWD      = 6'd28;
  localparam logic [5:0] FN_HLT      = 6'd29;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JTGT   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] DST_RD   = 2'd0;
  localparam logic [1:0] DST_RT   = 2'd1;
  localparam logic [1:0] DST_LINK = 2'd2;

  localparam logic [1:0] WBSEL_ALUOUT = 2'd0;
  localparam logic [1:0] WBSEL_MDR    = 2'd1;
  localparam logic [1:0] WBSEL_PC     = 2'd2;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_pc_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       output_active;
    logic       inst_done;
    logic       halted;
  } ctrl_t;

  logic [2:0] state_q, state_d;
  ctrl_t      ctrl, ctrl_out;

  logic is_rtype, is_ralu, is_jpr, is_jrl, is_wwd, is_hlt;
  logic is_branch, is_adi, is_ori_lhi, is_lwd, is_swd, is_jmp, is_jal;
  logic needs_ex;

  // The datapath gates the conditional PC load with bcond itself; the
  // controller only raises pc_write_cond, so bcond is not consumed here.
  logic unused_bcond;
  assign unused_bcond = bcond;

  // Instruction class decode from IR fields.
  always_comb begin
    is_rtype   = (opcode == OP_RTYPE);
    is_ralu    = is_rtype && (funct <= FN_ALU_LAST);
    is_jpr     = is_rtype && (funct == FN_JPR);
    is_jrl     = is_rtype && (funct == FN_JRL);
    is_wwd     = is_rtype && (funct == FN_WWD);
    is_hlt     = is_rtype && (funct == FN_HLT);
    is_branch  = (opcode <= OP_BLZ);
    is_adi     = (opcode == OP_ADI);
    is_ori_lhi = (opcode == OP_ORI) || (opcode == OP_LHI);
    is_lwd     = (opcode == OP_LWD);
    is_swd     = (opcode == OP_SWD);
    is_jmp     = (opcode == OP_JMP);
    is_jal     = (opcode == OP_JAL);
    needs_ex   = is_branch | is_adi | is_ori_lhi | is_lwd | is_swd | is_ralu;
  end

  // Next-state and per-state strobe generation (Mealy on mem_ack in IF/MEM).
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b0;
        if (mem_ack) begin
          // PC <= PC + 1 in the same cycle the fetched word lands in IR.
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_ALU;
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_ONE;
          ctrl.alu_pc_op = 1'b1;
          state_d        = S_ID;
        end
      end
      S_ID: begin
        // Branch target PC + sext(imm) is computed here and parked in ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_pc_op = 1'b1;
        if (is_jmp || is_jal) begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_JTGT;
          ctrl.inst_done = 1'b1;
          if (is_jal) begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DST_LINK;
            ctrl.mem_to_reg = WBSEL_PC;
          end
          state_d = S_IF;
        end else if (is_jpr || is_jrl) begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_RS;
          ctrl.inst_done = 1'b1;
          if (is_jrl) begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DST_LINK;
            ctrl.mem_to_reg = WBSEL_PC;
          end
          state_d = S_IF;
        end else if (is_wwd) begin
          ctrl.output_active = 1'b1;
          ctrl.inst_done     = 1'b1;
          state_d            = S_IF;
        end else if (is_hlt) begin
          ctrl.inst_done = 1'b1;
          state_d        = S_HALT;
        end else if (needs_ex) begin
          state_d = S_EX;
        end else begin
          // Undefined opcode/funct retires as a NOP.
          ctrl.inst_done = 1'b1;
          state_d        = S_IF;
        end
      end
      S_EX: begin
        ctrl.alu_src_a = 1'b1;
        if (is_branch) begin
          ctrl.alu_src_b     = SRCB_RT;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCS_ALUOUT;
          ctrl.inst_done     = 1'b1;
          state_d            = S_IF;
        end else if (is_ralu) begin
          ctrl.alu_src_b = SRCB_RT;
          state_d        = S_WB;
        end else if (is_adi) begin
          ctrl.alu_src_b = SRCB_SEXT;
          state_d        = S_WB;
        end else if (is_ori_lhi) begin
          ctrl.alu_src_b = SRCB_ZEXT;
          state_d        = S_WB;
        end else if (is_lwd || is_swd) begin
          ctrl.alu_src_b = SRCB_SEXT;
          state_d        = S_MEM;
        end else begin
          // Only reachable if IR changed under us; retire rather than hang.
          ctrl.inst_done = 1'b1;
          state_d        = S_IF;
        end
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = is_swd;
        ctrl.mem_read  = ~is_swd;
        if (mem_ack) begin
          if (is_swd) begin
            ctrl.inst_done = 1'b1;
            state_d        = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = is_ralu ? DST_RD : DST_RT;
        ctrl.mem_to_reg = is_lwd ? WBSEL_MDR : WBSEL_ALUOUT;
        ctrl.inst_done  = 1'b1;
        state_d         = S_IF;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // State register; reset lands in IF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  // Force every strobe low while reset is held so no request leaks out of
  // IF during reset; the first fetch appears as soon as reset_n rises.
  always_comb begin
    ctrl_out = reset_n ? ctrl : '0;
  end

  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign i_or_d        = ctrl_out.i_or_d;
  assign ir_write      = ctrl_out.ir_write;
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_source     = ctrl_out.pc_source;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_pc_op     = ctrl_out.alu_pc_op;
  assign reg_write     = ctrl_out.reg_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign output_active = ctrl_out.output_active;
  assign inst_done     = ctrl_out.inst_done;
  assign halted        = ctrl_out.halted;
  assign state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed + randomized instruction stream for
// mc_control_fsm, checked cycle by cycle against an instruction-level model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic [5:0] funct;
  logic       bcond;
  logic       mem_ack;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, alu_pc_op, reg_write, output_active, inst_done, halted;
  logic [2:0] state;

  mc_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .bcond(bcond), .mem_ack(mem_ack), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_pc_op(alu_pc_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .output_active(output_active), .inst_done(inst_done), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_pc_op, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       output_active, inst_done, halted;
    logic [2:0] state;
  } obs_t;

  typedef enum int {K_RALU, K_ADI, K_ORI_LHI, K_LWD, K_SWD, K_BR, K_JMP, K_JAL,
                    K_JPR, K_JRL, K_WWD, K_HLT, K_NOP} kind_t;

  obs_t obs;
  always_comb begin
    obs               = '0;
    obs.mem_read      = mem_read;
    obs.mem_write     = mem_write;
    obs.i_or_d        = i_or_d;
    obs.ir_write      = ir_write;
    obs.pc_write      = pc_write;
    obs.pc_write_cond = pc_write_cond;
    obs.pc_source     = pc_source;
    obs.alu_src_a     = alu_src_a;
    obs.alu_src_b     = alu_src_b;
    obs.alu_pc_op     = alu_pc_op;
    obs.reg_write     = reg_write;
    obs.reg_dst       = reg_dst;
    obs.mem_to_reg    = mem_to_reg;
    obs.output_active = output_active;
    obs.inst_done     = inst_done;
    obs.halted        = halted;
    obs.state         = state;
  end

  int errors = 0;
  int checks = 0;
  int n_instr = 0;
  int issued = 0;
  int done_seen = 0;
  int cyc_i;
  int done_at;

  // Classification straight from the ISA opcode/funct tables.
  function automatic kind_t classify(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd3) return K_BR;
    case (op)
      4'd4:       return K_ADI;
      4'd5, 4'd6: return K_ORI_LHI;
      4'd7:       return K_LWD;
      4'd8:       return K_SWD;
      4'd9:       return K_JMP;
      4'd10:      return K_JAL;
      4'd15: begin
        if (fn <= 6'd7) return K_RALU;
        case (fn)
          6'd25: return K_JPR;
          6'd26: return K_JRL;
          6'd28: return K_WWD;
          6'd29: return K_HLT;
          default: return K_NOP;
        endcase
      end
      default: return K_NOP;
    endcase
  endfunction

  // Zero-wait cycles per instruction, from the timing table.
  function automatic int cpi(input kind_t k);
    case (k)
      K_BR:                       return 3;
      K_RALU, K_ADI, K_ORI_LHI:   return 4;
      K_SWD:                      return 4;
      K_LWD:                      return 5;
      default:                    return 2;
    endcase
  endfunction

  task automatic check(input obs_t e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s instr=%0d observed=%h expected=%h", tag, n_instr, obs, e);
    end
  endtask

  // One clock: apply mem_ack, check outputs mid-cycle, advance past the edge.
  task automatic step(input obs_t e, input logic ack, input string tag);
    mem_ack = ack;
    bcond   = 1'($urandom);
    #1;
    check(e, tag);
    cyc_i++;
    if (obs.inst_done === 1'b1) begin
      done_seen++;
      if (done_at < 0) done_at = cyc_i;
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction through the model; abort_mem resets the DUT in the
  // first MEM wait cycle instead of completing.
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input bit abort_mem);
    kind_t k;
    obs_t  e;
    k       = classify(op, fn);
    cyc_i   = 0;
    done_at = -1;
    n_instr++;
    // fetch: junk on IR fields, ack after fw wait cycles
    for (int w = 0; w <= fw; w++) begin
      opcode = 4'($urandom);
      funct  = 6'($urandom);
      e = '0; e.state = 3'd0; e.mem_read = 1'b1;
      if (w == fw) begin
        e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'd1; e.alu_pc_op = 1'b1;
      end
      step(e, (w == fw), "fetch");
    end
    opcode = op;
    funct  = fn;
    // decode
    e = '0; e.state = 3'd1; e.alu_src_b = 2'd2; e.alu_pc_op = 1'b1;
    case (k)
      K_JMP, K_JAL: begin e.pc_write = 1'b1; e.pc_source = 2'd2; e.inst_done = 1'b1; end
      K_JPR, K_JRL: begin e.pc_write = 1'b1; e.pc_source = 2'd3; e.inst_done = 1'b1; end
      K_WWD:        begin e.output_active = 1'b1; e.inst_done = 1'b1; end
      K_HLT, K_NOP: e.inst_done = 1'b1;
      default: ;
    endcase
    if (k == K_JAL || k == K_JRL) begin
      e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
    end
    step(e, 1'($urandom), "decode");
    if (cpi(k) > 2) begin
      // execute
      e = '0; e.state = 3'd2; e.alu_src_a = 1'b1;
      case (k)
        K_ADI, K_LWD, K_SWD: e.alu_src_b = 2'd2;
        K_ORI_LHI:           e.alu_src_b = 2'd3;
        K_BR: begin e.pc_write_cond = 1'b1; e.pc_source = 2'd1; e.inst_done = 1'b1; end
        default: ;
      endcase
      step(e, 1'($urandom), "execute");
      if (k == K_LWD || k == K_SWD) begin
        for (int w = 0; w <= mw; w++) begin
          e = '0; e.state = 3'd3; e.i_or_d = 1'b1;
          e.mem_read = (k == K_LWD); e.mem_write = (k == K_SWD);
          if (abort_mem) begin
            mem_ack = 1'b0;
            #1;
            check(e, "mem_before_reset");
            reset_n = 1'b0;
            #1;
            check('0, "reset_in_mem");
            @(posedge clk);
            #1;
            check('0, "reset_held");
            @(negedge clk);
            reset_n = 1'b1;
            #1;
            e = '0; e.mem_read = 1'b1;
            check(e, "first_fetch_after_reset");
            @(posedge clk);
            #1;
            return;
          end
          if (w == mw && k == K_SWD) e.inst_done = 1'b1;
          step(e, (w == mw), "memory");
        end
      end
      if (k != K_BR && k != K_SWD) begin
        e = '0; e.state = 3'd4; e.reg_write = 1'b1; e.inst_done = 1'b1;
        e.reg_dst    = (k == K_RALU) ? 2'd0 : 2'd1;
        e.mem_to_reg = (k == K_LWD) ? 2'd1 : 2'd0;
        step(e, 1'($urandom), "writeback");
      end
    end
    issued++;
    checks++;
    assert (done_at == cpi(k) + fw + ((k == K_LWD || k == K_SWD) ? mw : 0)) else begin
      errors++;
      $error("FAIL done_cycle instr=%0d op=%0d fn=%0d observed=%0d expected=%0d",
             n_instr, op, fn, done_at, cpi(k) + fw + ((k == K_LWD || k == K_SWD) ? mw : 0));
    end
  endtask

  initial begin
    logic [3:0] rop;
    logic [5:0] rfn;
    obs_t       e;
    int         sel;
    reset_n = 1'b0;
    opcode  = '0;
    funct   = '0;
    bcond   = 1'b0;
    mem_ack = 1'b1;
    #2;
    check('0, "reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    check('0, "reset_outputs_clocked");
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // directed
    run_instr(4'd15, 6'd0, 0, 0, 1'b0);  // ADD
    run_instr(4'd7, 6'd0, 2, 1, 1'b0);   // LWD, 8 cycles
    run_instr(4'd1, 6'd0, 0, 0, 1'b0);   // BEQ (bcond random each cycle)
    run_instr(4'd1, 6'd3, 0, 0, 1'b0);   // BEQ again
    run_instr(4'd10, 6'd0, 0, 0, 1'b0);  // JAL
    run_instr(4'd8, 6'd0, 1, 2, 1'b0);   // SWD with waits
    run_instr(4'd12, 6'd0, 0, 0, 1'b0);  // undefined opcode
    run_instr(4'd15, 6'd27, 0, 0, 1'b0); // undefined funct
    run_instr(4'd15, 6'd28, 0, 0, 1'b0); // WWD
    run_instr(4'd15, 6'd26, 0, 0, 1'b0); // JRL

    // randomized stream, HLT excluded until the end
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 3);
      rfn = 6'($urandom_range(0, 63));
      if (rop == 4'd15) begin
        if (sel == 1)      rfn = (rfn[0]) ? 6'd25 : ((rfn[1]) ? 6'd26 : 6'd28);
        else if (sel != 2) rfn = 6'($urandom_range(0, 7));
        if (rfn == 6'd29) rfn = 6'd30;
      end
      run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    // reset mid-LWD while waiting in MEM
    run_instr(4'd7, 6'd0, 0, 1, 1'b1);
    run_instr(4'd4, 6'd0, 0, 0, 1'b0);   // ADI resumes cleanly

    // HLT then absorbing HALT with mem_ack toggling
    run_instr(4'd15, 6'd29, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      e = '0; e.state = 3'd5; e.halted = 1'b1;
      step(e, 1'(i), "halt");
    end

    checks++;
    assert (done_seen == issued) else begin
      errors++;
      $error("FAIL inst_done_count observed=%0d expected=%0d", done_seen, issued);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
